// File: rtl/dcf77_frame_decoder.sv
// DCF77 minute-telegram decoder: collects the classified second bits, validates
// markers, parities and BCD ranges, and latches time/date on each minute mark.
package dcf77_pkg;
  typedef logic [3:0] bcd_t;
  typedef enum logic {HUNT = 1'b0, COLLECT = 1'b1} state_t;
endpackage

module dcf77_frame_decoder
  import dcf77_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_strobe,
  input  logic       bit_value,
  input  logic       minute_mark,
  output bcd_t [1:0] year,
  output bcd_t [1:0] month,
  output bcd_t [1:0] day,
  output bcd_t [1:0] hour,
  output bcd_t [1:0] minute,
  output bcd_t [1:0] second,
  output logic [2:0] day_of_week,
  output logic       valid,
  output logic       error,
  output logic       frame_ok
);

  localparam logic [5:0] FRAME_BITS = 6'd59;

  state_t      state, state_next;
  logic [5:0]  bit_count;
  logic [5:0]  store_idx;
  logic        start_bit;
  logic [58:20] time_bits;

  logic        store_bit, check_frame, overflow, sec_tick;

  bcd_t [1:0]  min_d, hour_d, day_d, month_d, year_d;
  logic [2:0]  dow_d;
  logic        parity_ok, digits_ok, range_ok, frame_good;

  // Candidate fields straight from the telegram bits; tens digits zero-extended.
  assign min_d   = {{1'b0, time_bits[27:25]}, time_bits[24:21]};
  assign hour_d  = {{2'b0, time_bits[34:33]}, time_bits[32:29]};
  assign day_d   = {{2'b0, time_bits[41:40]}, time_bits[39:36]};
  assign dow_d   = time_bits[44:42];
  assign month_d = {{3'b0, time_bits[49]}, time_bits[48:45]};
  assign year_d  = {time_bits[57:54], time_bits[53:50]};

  function automatic logic digit_ok(input bcd_t d);
    return d <= 4'd9;
  endfunction

  assign parity_ok = ~(^time_bits[28:21]) & ~(^time_bits[35:29]) & ~(^time_bits[58:36]);

  assign digits_ok = digit_ok(min_d[1])   & digit_ok(min_d[0])   &
                     digit_ok(hour_d[1])  & digit_ok(hour_d[0])  &
                     digit_ok(day_d[1])   & digit_ok(day_d[0])   &
                     digit_ok(month_d[1]) & digit_ok(month_d[0]) &
                     digit_ok(year_d[1])  & digit_ok(year_d[0]);

  assign range_ok = (min_d[1] <= 4'd5) &
                    ((hour_d[1] < 4'd2) | ((hour_d[1] == 4'd2) & (hour_d[0] <= 4'd3))) &
                    (day_d != 8'h00) &
                    ((day_d[1] < 4'd3) | ((day_d[1] == 4'd3) & (day_d[0] <= 4'd1))) &
                    (dow_d != 3'd0) &
                    (((month_d[1] == 4'd0) & (month_d[0] != 4'd0)) |
                     ((month_d[1] == 4'd1) & (month_d[0] <= 4'd2)));

  assign frame_good = (bit_count == FRAME_BITS) & ~start_bit & time_bits[20] &
                      parity_ok & digits_ok & range_ok;

  // A coincident strobe always lands as bit 0 of the frame the mark opens.
  assign store_idx = minute_mark ? 6'd0 : bit_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= HUNT;
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no latch is inferred.
    state_next  = state;
    store_bit   = 1'b0;
    check_frame = 1'b0;
    overflow    = 1'b0;
    sec_tick    = 1'b0;
    if (minute_mark) begin
      state_next  = COLLECT;
      check_frame = (state == COLLECT);
      store_bit   = bit_strobe;
    end else if (bit_strobe && state == COLLECT) begin
      sec_tick = (bit_count != 6'd0);
      if (bit_count < FRAME_BITS) begin
        store_bit = 1'b1;
      end else begin
        overflow   = 1'b1;
        state_next = HUNT;
      end
    end
  end

  // NOTE: telegram bits carry no reset; bit_count must reach 59 before they are read.
  // Bits 1-19 (civil warning, call bit, DST flags) are not checked, so not stored.
  always_ff @(posedge clk) begin
    if (store_bit) begin
      if (store_idx == 6'd0)       start_bit            <= bit_value;
      else if (store_idx >= 6'd20) time_bits[store_idx] <= bit_value;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_count   <= '0;
      second      <= '0;
      year        <= '0;
      month       <= '0;
      day         <= '0;
      hour        <= '0;
      minute      <= '0;
      day_of_week <= '0;
      valid       <= 1'b0;
      error       <= 1'b0;
      frame_ok    <= 1'b0;
    end else begin
      frame_ok <= 1'b0;

      if (store_bit)        bit_count <= store_idx + 6'd1;
      else if (minute_mark) bit_count <= '0;

      if (minute_mark) begin
        second <= '0;
      end else if (sec_tick && second != 8'h59) begin
        if (second[0] == 4'd9) second <= {second[1] + 4'd1, 4'd0};
        else                   second[0] <= second[0] + 4'd1;
      end

      if (check_frame) begin
        if (frame_good) begin
          year        <= year_d;
          month       <= month_d;
          day         <= day_d;
          hour        <= hour_d;
          minute      <= min_d;
          day_of_week <= dow_d;
          valid       <= 1'b1;
          error       <= 1'b0;
          frame_ok    <= 1'b1;
        end else begin
          error <= 1'b1;
        end
      end else if (overflow) begin
        error <= 1'b1;
      end
    end
  end

endmodule

// File: doc/dcf77_frame_decoder.md
# dcf77_frame_decoder

Collects the 59 classified DCF77 second bits of one minute telegram, checks start/time marker bits, parities and BCD ranges, and on each minute mark latches the decoded time and date as BCD fields. It sits between the pulse-width bit classifier upstream and the 7-segment display decoder downstream. It also runs a seconds count so the display ticks between telegrams. Its outputs are the `year`/`month`/`day`/`hour`/`minute`/`second`/`day_of_week` bus consumed by the display decoder.

## Interface
- No parameters.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `bit_strobe`  in  1  one-cycle pulse: one telegram bit classified.
- `bit_value`  in  1  bit value, qualified by `bit_strobe`.
- `minute_mark`  in  1  one-cycle pulse: 59th-second gap detected, second 0 begins.
- `year, month, day, hour, minute, second`  out  `bcd_t [1:0]` each  decoded BCD fields; `[1]` is the tens digit, `[0]` is the units digit.
- `day_of_week`  out  3  1 = Mon … 7 = Sun; 0 = unknown.
- `valid`  out  1  at least one good frame has been accepted since reset.
- `error`  out  1  the last minute mark was rejected.
- `frame_ok`  out  1  one-cycle pulse: a frame was accepted.

## Operation
- **Reset values:** state `HUNT`; `bit_count` = 0; all BCD fields = 0; `day_of_week` = 0; `valid`, `error`, `frame_ok` = 0.
- **States:**
  - `HUNT`: discard bits. Move to `COLLECT` on `minute_mark`. No frame check on this first mark; only `second` is cleared.
  - `COLLECT`: on `bit_strobe`, if `bit_count` < 59, write `data[bit_count]` = `bit_value` and increment `bit_count`.
  - **Overflow:** a `bit_strobe` arriving with `bit_count` == 59 → go to `HUNT`, set `error` = 1, keep the fields.
- **Frame check on `minute_mark` in `COLLECT`:** accept only if all of the following hold:
  - `bit_count` == 59;
  - `data[0]` == 0 and `data[20]` == 1;
  - even parity over `data[21:28]`, `data[29:35]` and `data[36:58]`;
  - every BCD digit ≤ 9;
  - minute ≤ 59, hour ≤ 23, day 1–31, `day_of_week` 1–7, month 1–12.
- **Field bits** (LSB first):
  - minute: units 21–24, tens 25–27;
  - hour: units 29–32, tens 33–34;
  - day: units 36–39, tens 40–41;
  - `day_of_week`: 42–44;
  - month: units 45–48, tens 49;
  - year: units 50–53, tens 54–57.
  - Unused tens bits are zero-extended.
- **Accept:** latch all fields; `valid` = 1; `error` = 0; pulse `frame_ok`.
- **Reject:** hold the fields; `error` = 1; `valid` is unchanged.
- **Every `minute_mark`** (in any state): `second` = 00 and `bit_count` = 0, so a new frame starts.
- **Seconds count:** every `bit_strobe` in `COLLECT` except the one that stores bit index 0 increments `second` as a BCD count (09 → 10). `second` saturates at 59.
- **Simultaneous `minute_mark` and `bit_strobe`:** evaluate the old frame first. The strobed bit is then stored as bit 0 of the new frame, giving `bit_count` = 1 and `second` = 00.
- Leap-second frames (60 bits) are rejected through the overflow path.

## Timing
- Registered outputs. Fields, `error`, `valid` and `frame_ok` update on the clock edge that samples `minute_mark`, so they are visible in the next cycle.
- `frame_ok` is high for exactly one cycle.
- `second` updates on the edge that samples `bit_strobe` or `minute_mark`.
- Strobes are single-cycle with arbitrary spacing; at most one `bit_strobe` per cycle.
- Asserting `reset` mid-frame immediately forces the reset values. Bits received before the next `minute_mark` are ignored.

## Test plan
- **Good frame:** reset; `minute_mark`; then 59 bits encoding 14:32, Fri (5), 17.05.24, with P1 = 1, P2 = 0, P3 = 0; then `minute_mark` → next cycle `hour` = 1,4; `minute` = 3,2; `day` = 1,7; `month` = 0,5; `year` = 2,4; `day_of_week` = 5; `valid` = 1; `error` = 0; one-cycle `frame_ok`; `second` = 00.
- **Parity fault:** same frame with P1 = 0 → `error` = 1; fields remain at the previous values (00 after reset); `valid` = 0; no `frame_ok`.
- **Range fault:** good parities but minute field = 6,0 → rejected, `error` = 1.
- **Short and long frames:** 58 bits before `minute_mark` → `error` = 1. A 60th `bit_strobe` → state `HUNT`, `error` = 1. The next `minute_mark` resumes `COLLECT` with no check.
- **Seconds tick:** after a mark, 10 strobes → `second` = 0,9; one more → 1,0; 70 strobes total → overflow, `second` saturated at 5,9.
- **Coincident events and reset:** `minute_mark` together with `bit_strobe` (`bit_value` = 0) at the end of a good frame → frame accepted and `bit_count` = 1. Asserting `reset` at bit 30 → all outputs 0 immediately.
